// File: rtl/tally_period_ctrl.sv
// tally_period_ctrl: session/period sequencer for the 4x4 people-tally counter bank.
// Runs the per-period second timer, arbitrates category count requests onto one
// shared saturating incrementer, and publishes a frame-synchronous 256-bit snapshot.
module tally_period_ctrl #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int PERIOD_SECS = 60,
    parameter int MAX_COUNT   = 9999
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         pause,
    input  logic         clear,
    input  logic [3:0]   evt_req,
    input  logic         frame_sync,
    output logic [255:0] data_raw,
    output logic [1:0]   period_idx,
    output logic [7:0]   sec_left,
    output logic [1:0]   state_o,
    output logic         evt_drop
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_PAUSED = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        SECS_INIT = 8'(PERIOD_SECS);
    localparam logic [15:0]       CNT_MAX   = 16'(MAX_COUNT);

    // Round-robin pick: first pending bit at or after ptr, wrapping. Returns {valid, category}.
    function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cat;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cat = ptr + 2'(k);
            if (pend[cat]) begin
                res = {1'b1, cat};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [1:0]        state_q,  state_d;
    logic [TICK_W-1:0] tick_q,   tick_d;
    logic [7:0]        sec_q,    sec_d;
    logic [1:0]        period_q, period_d;
    logic [3:0]        pend_q,   pend_d;
    logic [1:0]        ptr_q,    ptr_d;
    logic              drop_q,   drop_d;
    logic [15:0]       cnt_q [16];
    logic [15:0]       cnt_d [16];
    logic [255:0]      data_q,   data_d;

    logic [2:0]        pick_s;
    logic              gnt_vld_s;
    logic [1:0]        gnt_cat_s;
    logic [3:0]        gnt_s;
    logic [3:0]        cnt_idx_s;

    // Arbiter: grant one pending category per cycle, only while running.
    always_comb begin
        pick_s = rr_pick(pend_q, ptr_q);
        if (state_q == ST_RUN) begin
            gnt_vld_s = pick_s[2];
        end else begin
            gnt_vld_s = 1'b0;
        end
        gnt_cat_s = pick_s[1:0];
        if (gnt_vld_s) begin
            gnt_s = 4'b0001 << gnt_cat_s;
        end else begin
            gnt_s = 4'b0000;
        end
        // Registered period_idx: a grant on the boundary cycle lands in the old period.
        cnt_idx_s = {gnt_cat_s, period_q};
    end

    // Next state for FSM, timer, request pending bits and the counter bank.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        sec_d    = sec_q;
        period_d = period_q;
        pend_d   = pend_q;
        ptr_d    = ptr_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;

        if (gnt_vld_s) begin
            ptr_d = gnt_cat_s + 2'd1;
            if (cnt_q[cnt_idx_s] < CNT_MAX) begin
                cnt_d[cnt_idx_s] = cnt_q[cnt_idx_s] + 16'd1;
            end else begin
                cnt_d[cnt_idx_s] = cnt_q[cnt_idx_s];
            end
        end else begin
            ptr_d = ptr_q;
        end

        if (clear) begin
            state_d  = ST_IDLE;
            tick_d   = '0;
            sec_d    = SECS_INIT;
            period_d = 2'd0;
            pend_d   = 4'b0000;
            ptr_d    = 2'd0;
            drop_d   = 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt_d[i] = 16'd0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d  = ST_RUN;
                        tick_d   = '0;
                        sec_d    = SECS_INIT;
                        period_d = 2'd0;
                        pend_d   = 4'b0000;
                        ptr_d    = 2'd0;
                        drop_d   = 1'b0;
                        for (int i = 0; i < 16; i++) begin
                            cnt_d[i] = 16'd0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RUN: begin
                    // Granted bit clears, but a same-cycle request on it re-pends.
                    pend_d = (pend_q & ~gnt_s) | evt_req;
                    if (|(evt_req & pend_q & ~gnt_s)) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                    if (pause) begin
                        state_d = ST_PAUSED;
                        pend_d  = 4'b0000;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (sec_q == 8'd1) begin
                            if (period_q != 2'd3) begin
                                period_d = period_q + 2'd1;
                                sec_d    = SECS_INIT;
                            end else begin
                                state_d = ST_DONE;
                                sec_d   = 8'd0;
                                pend_d  = 4'b0000;
                            end
                        end else begin
                            sec_d = sec_q - 8'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                ST_PAUSED: begin
                    if (pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Snapshot: capture the live (pre-increment) counters on frame_sync, else hold.
    always_comb begin
        data_d = data_q;
        if (frame_sync) begin
            for (int i = 0; i < 16; i++) begin
                data_d[255 - 16*i -: 16] = cnt_q[i];
            end
        end else begin
            data_d = data_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            sec_q    <= SECS_INIT;
            period_q <= 2'd0;
            pend_q   <= 4'b0000;
            ptr_q    <= 2'd0;
            drop_q   <= 1'b0;
            data_q   <= 256'd0;
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            sec_q    <= sec_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            drop_q   <= drop_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_raw   = data_q;
    assign period_idx = period_q;
    assign sec_left   = sec_q;
    assign state_o    = state_q;
    assign evt_drop   = drop_q;

endmodule
